router_ctrl: RTL and testbench

- Packet-sequencing controller for the 1x3 router ingress path.
- Decodes the destination from the header byte and steps the header/data/parity register stage through its load phases.
- Generates one-hot write enables into the three output FIFOs and stalls the source (busy) on FIFO full or busy destination.
- Owns the per-port read-timeout soft resets that flush abandoned FIFOs.

---
 rtl/router_ctrl.sv | 82 ++++++++
 tb/tb_router_ctrl.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/router_ctrl.sv
// router_ctrl: 1x3 router ingress packet sequencer with per-port read-timeout flush
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_valid,
    input  logic [1:0] din,
    input  logic [2:0] full,
    input  logic [2:0] empty,
    input  logic [2:0] read_enb,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       fifo_full,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic [2:0] write_enb,
    output logic       busy,
    output logic [2:0] soft_reset
);
    typedef enum logic [2:0] {DECODE, LFD, LD, FULL, LAF, LPAR, CHK, WAIT} state_t;
    state_t           state_q, state_d;
    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       sr_q, sr_d;
    logic             wr, sr_hit;
    assign fifo_full   = (addr_q == 2'd3) ? 1'b0 : full[addr_q];
    assign sr_hit      = (addr_q == 2'd3) ? 1'b0 : sr_q[addr_q];
    assign detect_add  = state_q == DECODE;
    assign lfd_state   = state_q == LFD;
    assign ld_state    = state_q == LD;
    assign full_state  = state_q == FULL;
    assign laf_state   = state_q == LAF;
    assign rst_int_reg = state_q == CHK;
    assign busy        = !(state_q == DECODE || state_q == LD);
    assign wr          = state_q == LFD || state_q == LD || state_q == LPAR || state_q == LAF;
    assign write_enb   = (wr && addr_q != 2'd3) ? (3'b001 << addr_q) : 3'b000;
    assign soft_reset  = sr_q;
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE: if (pkt_valid && din != 2'd3) begin
                addr_d  = din;
                state_d = empty[din] ? LFD : WAIT;
            end
            WAIT:   state_d = empty[addr_q] ? LFD : WAIT;
            LFD:    state_d = LD;
            LD:     state_d = fifo_full ? FULL : (!pkt_valid ? LPAR : LD);
            FULL:   state_d = fifo_full ? FULL : LAF;
            LAF:    state_d = parity_done ? DECODE : (low_pkt_valid ? LPAR : LD);
            LPAR:   state_d = CHK;
            CHK:    state_d = fifo_full ? FULL : DECODE;
            default: state_d = DECODE;
        endcase
        // a flush of the port we are serving abandons the packet from any phase
        if (state_q != DECODE && sr_hit) state_d = DECODE;
        for (int i = 0; i < 3; i++) begin
            sr_d[i]  = !read_enb[i] && !empty[i] && cnt_q[i] == CNT_W'(TIMEOUT - 1);
            cnt_d[i] = (read_enb[i] || empty[i] || sr_d[i]) ? '0 : cnt_q[i] + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DECODE;
            addr_q  <= 2'd0;
            sr_q    <= 3'b000;
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_router_ctrl.sv
// tb_router_ctrl: scoreboard bench for router_ctrl, directed plan plus randomized traffic
module tb_router_ctrl;
    localparam int TIMEOUT = 30;
    localparam int P_DEC = 0, P_LFD = 1, P_LD = 2, P_FULL = 3, P_LAF = 4, P_LPAR = 5, P_CHK = 6, P_WAIT = 7;
    logic clk = 1'b0;
    logic rst, pkt_valid, parity_done, low_pkt_valid;
    logic [1:0] din;
    logic [2:0] full, empty, read_enb;
    logic fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy;
    logic [2:0] write_enb, soft_reset;
    logic [13:0] exp_q[$];
    int n_chk = 0, n_pass = 0;
    int ph = P_DEC;
    logic [1:0] m_addr = 2'd0;
    int run[3] = '{0, 0, 0};
    logic [2:0] m_sr = 3'b000;

    router_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din), .full(full), .empty(empty),
        .read_enb(read_enb), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb(write_enb), .busy(busy), .soft_reset(soft_reset)
    );

    always #5 clk = ~clk;

    function automatic logic m_ff();
        return (m_addr != 2'd3) && full[m_addr];
    endfunction

    // packet phase advances one step per edge; timeouts counted as idle run lengths
    task automatic model_edge();
        logic ff, hit;
        int nph;
        if (rst) begin
            ph = P_DEC; m_addr = 2'd0; run = '{0, 0, 0}; m_sr = 3'b000;
            return;
        end
        ff  = m_ff();
        hit = (m_addr != 2'd3) && m_sr[m_addr];
        nph = ph;
        case (ph)
            P_DEC:  if (pkt_valid && din != 2'd3) begin nph = empty[din] ? P_LFD : P_WAIT; m_addr = din; end
            P_WAIT: if (empty[m_addr]) nph = P_LFD;
            P_LFD:  nph = P_LD;
            P_LD:   nph = ff ? P_FULL : (!pkt_valid ? P_LPAR : P_LD);
            P_FULL: if (!ff) nph = P_LAF;
            P_LAF:  nph = parity_done ? P_DEC : (low_pkt_valid ? P_LPAR : P_LD);
            P_LPAR: nph = P_CHK;
            P_CHK:  nph = ff ? P_FULL : P_DEC;
            default: nph = P_DEC;
        endcase
        if (ph != P_DEC && hit) nph = P_DEC;
        ph = nph;
        for (int i = 0; i < 3; i++) begin
            if (!read_enb[i] && !empty[i]) begin
                run[i]++;
                m_sr[i] = (run[i] % TIMEOUT) == 0;
            end else begin
                run[i] = 0;
                m_sr[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [13:0] expected();
        logic wr;
        logic [2:0] we;
        wr = ph == P_LFD || ph == P_LD || ph == P_LPAR || ph == P_LAF;
        we = (wr && m_addr != 2'd3) ? (3'b001 << m_addr) : 3'b000;
        return {m_ff(), ph == P_DEC, ph == P_LFD, ph == P_LD, ph == P_LAF, ph == P_FULL, ph == P_CHK,
                we, !(ph == P_DEC || ph == P_LD), m_sr};
    endfunction

    task automatic step(input logic pv, input logic [1:0] d, input logic [2:0] f, e, r,
                        input logic pd, lp, rs);
        pkt_valid = pv; din = d; full = f; empty = e; read_enb = r;
        parity_done = pd; low_pkt_valid = lp; rst = rs;
        @(posedge clk);
        model_edge();
        exp_q.push_back(expected());
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [13:0] act, exp_v;
            exp_v = exp_q.pop_front();
            act = {fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                   write_enb, busy, soft_reset};
            n_chk++;
            if (act === exp_v) n_pass++;
            else $display("FAIL outputs t=%0t got ff=%b da/lfd/ld/laf/full/chk=%b we=%b busy=%b sr=%b expected ff=%b da/lfd/ld/laf/full/chk=%b we=%b busy=%b sr=%b",
                          $time, act[13], act[12:7], act[6:4], act[3], act[2:0],
                          exp_v[13], exp_v[12:7], exp_v[6:4], exp_v[3], exp_v[2:0]);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] e_seg;
        pkt_valid = 0; din = 0; full = 0; empty = 3'b111; read_enb = 0;
        parity_done = 0; low_pkt_valid = 0; rst = 1;
        repeat (2) step(0, 0, 0, 3'b111, 0, 0, 0, 1);
        // addr 1 packet through LFD, LD, LPAR, CHK
        step(1, 1, 0, 3'b111, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 3'b111, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 3'b111, 0, 0, 0, 0);
        // addr 2 waits on a non-empty FIFO
        repeat (2) step(1, 2, 0, 3'b011, 0, 0, 0, 0);
        step(1, 2, 0, 3'b111, 0, 0, 0, 0);
        step(1, 2, 0, 3'b111, 0, 0, 0, 0);
        repeat (3) step(0, 0, 0, 3'b111, 0, 0, 0, 0);
        // full stall then each LAF exit: parity_done, low_pkt_valid, neither
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 3'b111, 0, 0, 0, 0);
            step(1, 0, 0, 3'b111, 0, 0, 0, 0);
            repeat (2) step(1, 0, 3'b001, 3'b111, 0, 0, 0, 0);
            step(1, 0, 0, 3'b111, 0, 0, 0, 0);
            step(1, 0, 0, 3'b111, 0, k == 0, k == 1, 0);
            repeat (4) step(0, 0, 0, 3'b111, 0, 0, 0, 0);
        end
        // invalid address is dropped
        repeat (4) step(1, 3, 0, 3'b111, 0, 0, 0, 0);
        // port 1 timeout, then a read at terminal count suppresses it
        repeat (32) step(0, 0, 0, 3'b101, 0, 0, 0, 0);
        step(0, 0, 0, 3'b111, 0, 0, 0, 0);
        for (int i = 1; i <= 32; i++) step(0, 0, 0, 3'b101, (i == 30) ? 3'b010 : 3'b000, 0, 0, 0);
        step(0, 0, 0, 3'b111, 0, 0, 0, 0);
        // flush while loading addr 1
        step(1, 1, 0, 3'b111, 0, 0, 0, 0);
        repeat (33) step(1, 1, 0, 3'b101, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 3'b111, 0, 0, 0, 0);
        // reset in FULL with port 0 counter at 20
        step(1, 0, 0, 3'b111, 0, 0, 0, 0);
        step(1, 0, 0, 3'b110, 0, 0, 0, 0);
        repeat (19) step(1, 0, 3'b001, 3'b110, 0, 0, 0, 0);
        step(1, 0, 3'b001, 3'b110, 0, 0, 0, 1);
        repeat (32) step(0, 0, 0, 3'b110, 0, 0, 0, 0);
        // randomized traffic in segments of steady FIFO occupancy
        for (int s = 0; s < 60; s++) begin
            e_seg = 3'($urandom);
            for (int c = 0; c < 50; c++)
                step($urandom_range(0, 9) > 1, 2'($urandom), ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000,
                     ($urandom_range(0, 9) == 0) ? 3'($urandom) : e_seg,
                     ($urandom_range(0, 19) == 0) ? 3'($urandom) : 3'b000,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
        end
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
